// File: rtl/mem_arbiter.sv
// mem_arbiter: two-port (instruction fetch / data) arbiter feeding a single AXI bridge request channel.
//   clock, reset           : rising-edge clock, synchronous active-high reset
//   imem_valid/addr        : fetch request pulse and byte address
//   imem_rdata/ready       : fetch response, routed combinationally from the bridge
//   dmem_valid/addr/wdata/wstrb : data request pulse; wstrb 0 = load, nonzero = store
//   dmem_rdata/ready       : data response, routed combinationally from the bridge
//   axi_valid/instr/addr/wdata/wstrb : registered one-cycle request to the bridge
//   axi_rdata/ready        : bridge response
//   MEM_ARBITER_RR_EN      : when defined, alternate between ports when both are pending;
//                            otherwise data has fixed priority
module mem_arbiter (
    input  logic        clock,
    input  logic        reset,
    input  logic        imem_valid,
    input  logic [31:0] imem_addr,
    output logic [31:0] imem_rdata,
    output logic        imem_ready,
    input  logic        dmem_valid,
    input  logic [31:0] dmem_addr,
    input  logic [31:0] dmem_wdata,
    input  logic [3:0]  dmem_wstrb,
    output logic [31:0] dmem_rdata,
    output logic        dmem_ready,
    output logic        axi_valid,
    output logic        axi_instr,
    output logic [31:0] axi_addr,
    output logic [31:0] axi_wdata,
    output logic [3:0]  axi_wstrb,
    input  logic [31:0] axi_rdata,
    input  logic        axi_ready
);
    typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D} state_t;
    state_t      state_q, state_d;
    logic        slot_i_v_q, slot_i_v_d, slot_d_v_q, slot_d_v_d;
    logic [31:0] slot_i_addr_q, slot_i_addr_d, slot_d_addr_q, slot_d_addr_d;
    logic [31:0] slot_d_wdata_q, slot_d_wdata_d;
    logic [3:0]  slot_d_wstrb_q, slot_d_wstrb_d;
    logic        axi_valid_q, axi_valid_d, axi_instr_q, axi_instr_d;
    logic [31:0] axi_addr_q, axi_addr_d, axi_wdata_q, axi_wdata_d;
    logic [3:0]  axi_wstrb_q, axi_wstrb_d;
    logic        done, free, acc_i, acc_d, pend_i, pend_d, prefer_i, gnt_i, gnt_d;
`ifdef MEM_ARBITER_RR_EN
    logic        last_i_q, last_i_d;
`endif

    always_comb begin
        done           = (state_q != IDLE) && axi_ready;
        // A grant may be decided in IDLE or in the response cycle itself, so the
        // registered axi_valid lands on the cycle after the bridge went idle.
        free           = (state_q == IDLE) || done;
        // The owner port may re-request only in its own response cycle.
        acc_i          = imem_valid && !slot_i_v_q && (state_q != BUSY_I || axi_ready);
        acc_d          = dmem_valid && !slot_d_v_q && (state_q != BUSY_D || axi_ready);
        // A request arriving this cycle is visible to arbitration immediately.
        pend_i         = slot_i_v_q || acc_i;
        pend_d         = slot_d_v_q || acc_d;
        slot_i_addr_d  = slot_i_v_q ? slot_i_addr_q : imem_addr;
        slot_d_addr_d  = slot_d_v_q ? slot_d_addr_q : dmem_addr;
        slot_d_wdata_d = slot_d_v_q ? slot_d_wdata_q : dmem_wdata;
        slot_d_wstrb_d = slot_d_v_q ? slot_d_wstrb_q : dmem_wstrb;
`ifdef MEM_ARBITER_RR_EN
        prefer_i       = !last_i_q;
`else
        prefer_i       = 1'b0;
`endif
        gnt_d          = free && pend_d && !(pend_i && prefer_i);
        gnt_i          = free && pend_i && !gnt_d;
`ifdef MEM_ARBITER_RR_EN
        last_i_d       = gnt_i ? 1'b1 : gnt_d ? 1'b0 : last_i_q;
`endif
        slot_i_v_d     = pend_i && !gnt_i;
        slot_d_v_d     = pend_d && !gnt_d;
        state_d        = gnt_i ? BUSY_I : gnt_d ? BUSY_D : done ? IDLE : state_q;
        axi_valid_d    = gnt_i || gnt_d;
        axi_instr_d    = gnt_i;
        axi_addr_d     = gnt_i ? slot_i_addr_d : gnt_d ? slot_d_addr_d : 32'h0;
        axi_wdata_d    = gnt_d ? slot_d_wdata_d : 32'h0;
        axi_wstrb_d    = gnt_d ? slot_d_wstrb_d : 4'h0;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q        <= IDLE;
            slot_i_v_q     <= 1'b0;
            slot_d_v_q     <= 1'b0;
            slot_i_addr_q  <= 32'h0;
            slot_d_addr_q  <= 32'h0;
            slot_d_wdata_q <= 32'h0;
            slot_d_wstrb_q <= 4'h0;
            axi_valid_q    <= 1'b0;
            axi_instr_q    <= 1'b0;
            axi_addr_q     <= 32'h0;
            axi_wdata_q    <= 32'h0;
            axi_wstrb_q    <= 4'h0;
`ifdef MEM_ARBITER_RR_EN
            last_i_q       <= 1'b0;
`endif
        end else begin
            state_q        <= state_d;
            slot_i_v_q     <= slot_i_v_d;
            slot_d_v_q     <= slot_d_v_d;
            slot_i_addr_q  <= slot_i_addr_d;
            slot_d_addr_q  <= slot_d_addr_d;
            slot_d_wdata_q <= slot_d_wdata_d;
            slot_d_wstrb_q <= slot_d_wstrb_d;
            axi_valid_q    <= axi_valid_d;
            axi_instr_q    <= axi_instr_d;
            axi_addr_q     <= axi_addr_d;
            axi_wdata_q    <= axi_wdata_d;
            axi_wstrb_q    <= axi_wstrb_d;
`ifdef MEM_ARBITER_RR_EN
            last_i_q       <= last_i_d;
`endif
        end
    end

    assign axi_valid  = axi_valid_q;
    assign axi_instr  = axi_instr_q;
    assign axi_addr   = axi_addr_q;
    assign axi_wdata  = axi_wdata_q;
    assign axi_wstrb  = axi_wstrb_q;
    // Responses are masked while reset is held so an abandoned transaction never completes.
    assign imem_ready = !reset && state_q == BUSY_I && axi_ready;
    assign dmem_ready = !reset && state_q == BUSY_D && axi_ready;
    assign imem_rdata = imem_ready ? axi_rdata : 32'h0;
    assign dmem_rdata = dmem_ready ? axi_rdata : 32'h0;
endmodule
